alu_share_arbiter: RTL and testbench

- Shares the single combinational ALU (operands A, B; op select D; result C) between two requesters.
- Each requester has a valid/ready request channel and a one-entry response buffer with its own valid/ready handshake.
- Round-robin arbitration, one issue per cycle, fixed two-cycle accept-to-response latency.
- Sits between the pipeline's execute-stage users (e.g. integer path and address-generation path) and the ALU.

---
 rtl/alu_share_arbiter_pkg.sv | 17 +
 rtl/alu_share_arbiter_rr_arbiter2.sv | 33 +++
 rtl/alu_share_arbiter.sv | 153 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU sharing block.
// ALU op encodings are the values requesters place on their op field.
package alu_share_arbiter_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int OPW_DEF   = 3;
    localparam int NREQ      = 2;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef logic req_id_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the requester granted last loses a tie.
// Reusable for any unit shared by two clients with one grant per cycle.
module rr_arbiter2
    import alu_share_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output req_id_t    grant_id
);

    req_id_t last_reg;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_reg == 1'b1) ? 2'b01 : 2'b10;
        end
    end

    assign grant_id = req_id_t'(grant[1]);

    // Starting with last=1 gives requester 0 the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
        end else if (|grant) begin
            last_reg <= grant_id;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters with a
// one-entry response buffer each and a fixed two-cycle issue-to-response path.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_c,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_c,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_d,
    input  logic [WIDTH-1:0] alu_c,

    output logic [CNTW-1:0]  issue_cnt
);

    logic [NREQ-1:0]  req_valid;
    logic [NREQ-1:0]  rsp_ready;
    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  pending;
    logic [NREQ-1:0]  rsp_valid;
    logic [WIDTH-1:0] req_a [NREQ];
    logic [WIDTH-1:0] req_b [NREQ];
    logic [OPW-1:0]   req_op [NREQ];
    logic [WIDTH-1:0] rsp_c [NREQ];
    req_id_t          grant_id;
    logic             accept;

    logic             issue_valid_reg;
    logic [WIDTH-1:0] issue_a_reg;
    logic [WIDTH-1:0] issue_b_reg;
    logic [OPW-1:0]   issue_op_reg;
    req_id_t          issue_id_reg;
    logic [CNTW-1:0]  issue_cnt_reg;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;
    assign req_op[0] = req0_op;
    assign req_op[1] = req1_op;

    // Gating with rst_n keeps ready low while reset is held.
    assign eligible = req_valid & ~pending & {NREQ{rst_n}};

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (eligible),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign accept = |grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_reg <= 1'b0;
            issue_a_reg     <= '0;
            issue_b_reg     <= '0;
            issue_op_reg    <= '0;
            issue_id_reg    <= 1'b0;
            issue_cnt_reg   <= '0;
        end else begin
            issue_valid_reg <= accept;
            if (accept) begin
                issue_a_reg   <= req_a[grant_id];
                issue_b_reg   <= req_b[grant_id];
                issue_op_reg  <= req_op[grant_id];
                issue_id_reg  <= grant_id;
                issue_cnt_reg <= issue_cnt_reg + 1'b1;
            end
        end
    end

    // Idle ALU inputs are parked at zero so the ALU sees no stale toggling.
    assign alu_a     = issue_valid_reg ? issue_a_reg  : '0;
    assign alu_b     = issue_valid_reg ? issue_b_reg  : '0;
    assign alu_d     = issue_valid_reg ? issue_op_reg : '0;
    assign issue_cnt = issue_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rsp
            logic             pending_reg;
            logic             valid_reg;
            logic [WIDTH-1:0] c_reg;
            logic             capture;
            logic             drain;

            assign capture = issue_valid_reg && (issue_id_reg == req_id_t'(gi));
            assign drain   = valid_reg && rsp_ready[gi];

            // Pending blocks re-issue until drain, so capture never hits a full buffer.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pending_reg <= 1'b0;
                    valid_reg   <= 1'b0;
                    c_reg       <= '0;
                end else begin
                    if (grant[gi]) begin
                        pending_reg <= 1'b1;
                    end else if (drain) begin
                        pending_reg <= 1'b0;
                    end
                    if (capture) begin
                        valid_reg <= 1'b1;
                        c_reg     <= alu_c;
                    end else if (drain) begin
                        valid_reg <= 1'b0;
                    end
                end
            end

            assign pending[gi]   = pending_reg;
            assign rsp_valid[gi] = valid_reg;
            assign rsp_c[gi]     = c_reg;
        end
    endgenerate

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_c     = rsp_c[0];
    assign rsp1_c     = rsp_c[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a per-requester response scoreboard
// and a behavioural ALU model closing the alu_a/alu_b/alu_d -> alu_c loop.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int W  = 32;
    localparam int OW = 3;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b, rsp0_c, rsp1_c;
    logic [OW-1:0] req0_op, req1_op;
    logic [W-1:0]  alu_a, alu_b, alu_c;
    logic [OW-1:0] alu_d;
    logic [CW-1:0] issue_cnt;

    int            errors = 0;
    int            checks = 0;
    logic [W-1:0]  q0[$];
    logic [W-1:0]  q1[$];
    logic [OW-1:0] ops [5];

    function automatic logic [W-1:0] alu_model(logic [W-1:0] a, logic [W-1:0] b, logic [OW-1:0] op);
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: return a ^ b;
        endcase
    endfunction

    assign alu_c = alu_model(alu_a, alu_b, alu_d);

    alu_share_arbiter #(.WIDTH(W), .OPW(OW), .CNTW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_c     (rsp0_c),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_c     (rsp1_c),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_d      (alu_d),
        .alu_c      (alu_c),
        .issue_cnt  (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        cyc();
        rst_n = 1'b1;
    endtask

    always @(negedge rst_n) begin
        q0.delete();
        q1.delete();
    end

    // Scoreboard: push the model result on accept, pop and compare on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) chk("rsp0_unexpected", 32'(rsp0_valid), 32'(0));
                else chk("rsp0_scoreboard", rsp0_c, q0.pop_front());
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) chk("rsp1_unexpected", 32'(rsp1_valid), 32'(0));
                else chk("rsp1_scoreboard", rsp1_c, q1.pop_front());
            end
            if (req0_valid && req0_ready) q0.push_back(alu_model(req0_a, req0_b, req0_op));
            if (req1_valid && req1_ready) q1.push_back(alu_model(req1_a, req1_b, req1_op));
        end
    end

    initial begin
        int n;
        ops[0] = ALU_AND; ops[1] = ALU_OR; ops[2] = ALU_ADD; ops[3] = ALU_SUB; ops[4] = ALU_SLT;
        clk = 1'b0; rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = '0; rsp0_ready = 1'b1;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0; rsp1_ready = 1'b1;

        // Reset state: everything low even with a request presented.
        #2;
        chk("rst_req0_ready", 32'(req0_ready), 32'(0));
        chk("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'(0));
        chk("rst_rsp_c", rsp0_c | rsp1_c, 32'(0));
        chk("rst_alu", alu_a | alu_b | 32'(alu_d), 32'(0));
        chk("rst_issue_cnt", 32'(issue_cnt), 32'(0));
        cyc();
        rst_n = 1'b1;
        req0_valid = 1'b0;
        cyc();

        // Single op: 1 + 2, two-cycle latency.
        req0_valid = 1'b1; req0_a = 1; req0_b = 2; req0_op = ALU_ADD;
        #1 chk("t1_req0_ready", 32'(req0_ready), 32'(1));
        cyc();
        req0_valid = 1'b0;
        #1 chk("t1_alu_a", alu_a, 32'(1));
        chk("t1_alu_b", alu_b, 32'(2));
        chk("t1_alu_d", 32'(alu_d), 32'(ALU_ADD));
        chk("t1_rsp0_early", 32'(rsp0_valid), 32'(0));
        chk("t1_issue_cnt", 32'(issue_cnt), 32'(1));
        cyc();
        #1 chk("t1_rsp0_valid", 32'(rsp0_valid), 32'(1));
        chk("t1_rsp0_c", rsp0_c, 32'(3));
        cyc();
        #1 chk("t1_rsp0_drained", 32'(rsp0_valid), 32'(0));
        chk("t1_alu_idle", alu_a, 32'(0));

        // Contention after reset: 0 first, then 1, then 0 again on the next tie.
        do_reset();
        req0_valid = 1'b1; req0_a = 5; req0_b = 3; req0_op = ALU_SUB;
        req1_valid = 1'b1; req1_a = 4; req1_b = 4; req1_op = ALU_ADD;
        #1 chk("t2_grant0", 32'({req1_ready, req0_ready}), 32'(1));
        cyc();
        req0_valid = 1'b0;
        #1 chk("t2_grant1", 32'({req1_ready, req0_ready}), 32'(2));
        chk("t2_alu_a0", alu_a, 32'(5));
        cyc();
        req1_valid = 1'b0;
        #1 chk("t2_rsp0_c", rsp0_c, 32'(2));
        chk("t2_rsp0_valid", 32'(rsp0_valid), 32'(1));
        chk("t2_alu_d1", 32'(alu_d), 32'(ALU_ADD));
        cyc();
        #1 chk("t2_rsp1_valid", 32'(rsp1_valid), 32'(1));
        chk("t2_rsp1_c", rsp1_c, 32'(8));
        cyc();
        req0_valid = 1'b1; req0_a = 7; req0_b = 12; req0_op = ALU_AND;
        req1_valid = 1'b1; req1_a = 3; req1_b = 4; req1_op = ALU_OR;
        #1 chk("t2_regrant0", 32'({req1_ready, req0_ready}), 32'(1));
        cyc();
        req0_valid = 1'b0;
        #1 chk("t2_regrant1", 32'({req1_ready, req0_ready}), 32'(2));
        cyc();
        req1_valid = 1'b0;
        repeat (4) cyc();

        // Backpressure on requester 0 while requester 1 streams.
        do_reset();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 9; req0_b = 1; req0_op = ALU_ADD;
        req1_valid = 1'b1; req1_a = 100; req1_b = 1; req1_op = ALU_SUB;
        #1 chk("t3_req0_first", 32'(req0_ready), 32'(1));
        for (int i = 1; i <= 6; i++) begin
            cyc();
            #1 chk("t3_req0_blocked", 32'(req0_ready), 32'(0));
            chk("t3_req1_cadence", 32'(req1_ready), 32'(i % 3 == 1));
            if (i >= 2) begin
                chk("t3_rsp0_held_valid", 32'(rsp0_valid), 32'(1));
                chk("t3_rsp0_held_c", rsp0_c, 32'(10));
            end
            if (i == 6) rsp0_ready = 1'b1;
        end
        cyc();
        #1 chk("t3_req0_after_drain", 32'({req1_ready, req0_ready}), 32'(1));
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1 chk("t3_reissue_alu_a", alu_a, 32'(9));
        repeat (4) cyc();

        // Asynchronous reset in the execute cycle of an accepted op.
        do_reset();
        req0_valid = 1'b1; req0_a = 2; req0_b = 2; req0_op = ALU_ADD;
        #1 chk("t4_accept", 32'(req0_ready), 32'(1));
        cyc();
        #1 rst_n = 1'b0;
        #1 chk("t4_rst_alu", alu_a | alu_b | 32'(alu_d), 32'(0));
        chk("t4_rst_ready", 32'({req1_ready, req0_ready}), 32'(0));
        chk("t4_rst_cnt", 32'(issue_cnt), 32'(0));
        chk("t4_rst_rsp", 32'({rsp1_valid, rsp0_valid}), 32'(0));
        cyc();
        rst_n = 1'b1;
        #1 chk("t4_ready_after_release", 32'(req0_ready), 32'(1));
        chk("t4_no_stale_rsp", 32'(rsp0_valid), 32'(0));
        cyc();
        req0_valid = 1'b0;
        #1 chk("t4_no_stale_rsp2", 32'(rsp0_valid), 32'(0));
        cyc();
        #1 chk("t4_new_rsp_valid", 32'(rsp0_valid), 32'(1));
        chk("t4_new_rsp_c", rsp0_c, 32'(4));
        repeat (2) cyc();

        // Counter wrap: 17 accepts into a 4-bit counter.
        do_reset();
        n = 0;
        for (int i = 0; i < 100 && n < 17; i++) begin
            req0_valid = 1'b1; req0_a = 32'(i); req0_b = 32'(3); req0_op = ops[i % 5];
            req1_valid = 1'b1; req1_a = 32'(i * 7); req1_b = 32'(i); req1_op = ops[(i + 2) % 5];
            #1 n += int'(req0_ready) + int'(req1_ready);
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t5_accepts", 32'(n), 32'(17));
        chk("t5_issue_cnt_wrap", 32'(issue_cnt), 32'(1));
        repeat (3) cyc();

        // Idle: ALU inputs parked, no responses, counter frozen.
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t6_alu_idle", alu_a | alu_b | 32'(alu_d), 32'(0));
            chk("t6_rsp_idle", 32'({rsp1_valid, rsp0_valid}), 32'(0));
            chk("t6_cnt_frozen", 32'(issue_cnt), 32'(1));
        end

        chk("end_q0_empty", 32'(q0.size()), 32'(0));
        chk("end_q1_empty", 32'(q1.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
